// File: rtl/xtea_enc_arbiter.sv
// xtea_enc_arbiter: shares one xtea_enc core between two requesters.
//
// A job (plaintext, key) is accepted from either port through a valid/ready
// handshake, with round-robin arbitration when both ports are valid. The job
// is latched and launched into the core with a one-cycle start pulse. The
// core's one-cycle ready pulse captures the ciphertext, which is held on the
// response port until the consumer takes it.
//
// Ports:
//   clock, reset_n             clock and asynchronous active-low reset
//   req_valid/req_ready[1:0]   per-port job handshake (bit i = port i)
//   req_data0/1, req_key0/1    per-port plaintext and key
//   rsp_valid/rsp_ready        result handshake
//   rsp_id, rsp_data, rsp_err  issuing port, ciphertext, timeout flag
//   core_start, core_data_in,  start pulse and latched job to the core
//   core_key
//   core_ready, core_data_out  completion pulse and result from the core
//   core_rst                   reset request to the core (timeout only)
//   done_count                 completed-job counter, wraps at 0xFFFF
//
// Build option: define XTEA_ARB_TIMEOUT_EN to abort a job when the core has
// not answered within TIMEOUT cycles. Without it WAIT holds indefinitely and
// core_rst / rsp_err are constant 0.

module xtea_enc_arbiter #(
  parameter int unsigned WORD_SIZE = 128,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WORD_SIZE-1:0] req_data0,
  input  logic [WORD_SIZE-1:0] req_data1,
  input  logic [WORD_SIZE-1:0] req_key0,
  input  logic [WORD_SIZE-1:0] req_key1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 core_start,
  output logic [WORD_SIZE-1:0] core_data_in,
  output logic [WORD_SIZE-1:0] core_key,
  input  logic                 core_ready,
  input  logic [WORD_SIZE-1:0] core_data_out,
  output logic                 core_rst,
  output logic [15:0]          done_count
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   rsp_id_q, rsp_id_d;
  logic [WORD_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  logic [WORD_SIZE-1:0]   key_q, key_d;
  logic [15:0]            done_count_q, done_count_d;

  logic grant;
  logic accept;

`ifdef XTEA_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
  logic            core_rst_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant  = (&req_valid) ? ~last_grant_q : req_valid[1];
    accept = (state_q == StIdle) && (|req_valid);
    if (accept) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    data_d       = data_q;
    key_d        = key_q;
    done_count_d = done_count_q;
`ifdef XTEA_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
    core_rst_d   = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (accept) begin
          data_d   = grant ? req_data1 : req_data0;
          key_d    = grant ? req_key1  : req_key0;
          rsp_id_d = grant;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
`ifdef XTEA_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (core_ready) begin
          rsp_data_d = core_data_out;
`ifdef XTEA_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = StResp;
        end
`ifdef XTEA_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT)) begin
          core_rst_d = 1'b1;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StResp: begin
        if (rsp_ready) begin
          last_grant_d = rsp_id_q;
          done_count_d = done_count_q + 16'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      data_q       <= '0;
      key_q        <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      data_q       <= data_d;
      key_q        <= key_d;
      done_count_q <= done_count_d;
    end
  end

`ifdef XTEA_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // High only in the single WAIT cycle that gives up on the core.
  assign core_rst = core_rst_d;
  assign rsp_err  = rsp_err_q;
`else
  assign core_rst = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  assign core_start   = (state_q == StLaunch);
  assign core_data_in = data_q;
  assign core_key     = key_q;
  assign rsp_valid    = (state_q == StResp);
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign done_count   = done_count_q;

endmodule

// File: tb/tb_xtea_enc_arbiter.sv
// Testbench for xtea_enc_arbiter: table of arbitrated jobs plus directed
// sequences for response back-pressure, asynchronous reset mid-job, counter
// wrap and (with XTEA_ARB_TIMEOUT_EN) the core timeout.

module tb_xtea_enc_arbiter;

  localparam int unsigned W   = 128;
  localparam int unsigned Lat = 8;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_data0, req_data1, req_key0, req_key1;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         core_start, core_rst;
  logic [W-1:0] core_data_in, core_key, core_data_out;
  logic         core_ready, core_ready_m, spur, hang;
  logic [15:0]  done_count;

  int n_chk = 0;
  int n_fail = 0;
  int dual_hits = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clock = ~clock;

  assign core_ready = core_ready_m | spur;

  xtea_enc_arbiter #(.WORD_SIZE(W), .TIMEOUT(10)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .req_key0     (req_key0),
    .req_key1     (req_key1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .core_start   (core_start),
    .core_data_in (core_data_in),
    .core_key     (core_key),
    .core_ready   (core_ready),
    .core_data_out(core_data_out),
    .core_rst     (core_rst),
    .done_count   (done_count)
  );

  // Stand-in for the cipher core: a fixed keyed mix, Lat cycles after start.
  function automatic logic [W-1:0] model_f(input logic [W-1:0] d, input logic [W-1:0] k);
    return d ^ {k[63:0], k[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
  endfunction

  initial begin
    core_ready_m  = 1'b0;
    core_data_out = '0;
    forever begin
      @(negedge clock);
      if (core_start && !hang) begin
        repeat (Lat) @(posedge clock);
        #1;
        core_data_out = model_f(core_data_in, core_key);
        core_ready_m  = 1'b1;
        @(posedge clock);
        #1;
        core_ready_m  = 1'b0;
        core_data_out = '0;
      end
    end
  end

  always @(negedge clock) if (req_ready == 2'b11) dual_hits++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete job; hold > 0 keeps rsp_ready low that many cycles in RESP.
  task automatic do_job(input logic [1:0] valid, input logic [W-1:0] d0, input logic [W-1:0] k0,
                        input logic [W-1:0] d1, input logic [W-1:0] k1, input logic exp_id,
                        input int hold);
    logic [W-1:0] exp_d;
    logic [W-1:0] exp_k;
    bit           seen;
    exp_d = exp_id ? d1 : d0;
    exp_k = exp_id ? k1 : k0;
    @(posedge clock);
    #1;
    req_valid = valid;
    req_data0 = d0; req_key0 = k0;
    req_data1 = d1; req_key1 = k1;
    @(negedge clock);
    chk("req_ready_grant", W'(req_ready), W'(exp_id ? 2'b10 : 2'b01));
    chk("core_start_idle", W'(core_start), W'(0));
    @(posedge clock);
    #1;
    req_valid = 2'b00;
    req_data0 = '0; req_key0 = '0; req_data1 = '0; req_key1 = '0;
    @(negedge clock);
    chk("core_start_launch", W'(core_start), W'(1));
    chk("core_data_in", core_data_in, exp_d);
    chk("core_key", core_key, exp_k);
    @(negedge clock);
    chk("core_start_wait", W'(core_start), W'(0));
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (core_ready) seen = 1;
      else @(negedge clock);
    end
    chk("core_ready_seen", W'(seen), W'(1));
    chk("rsp_valid_before", W'(rsp_valid), W'(0));
    @(negedge clock);
    chk("rsp_valid_after", W'(rsp_valid), W'(1));
    chk("rsp_id", W'(rsp_id), W'(exp_id));
    chk("rsp_data", rsp_data, model_f(exp_d, exp_k));
    chk("rsp_err", W'(rsp_err), W'(0));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clock);
        #1;
        req_valid = 2'b11;
        spur      = (i == 10);
        @(negedge clock);
        chk("hold_data", rsp_data, model_f(exp_d, exp_k));
        chk("hold_req_ready", W'(req_ready), W'(0));
        chk("hold_rsp_valid", W'(rsp_valid), W'(1));
      end
      @(posedge clock);
      #1;
      spur      = 1'b0;
      req_valid = 2'b00;
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    chk("done_count", W'(done_count), W'(exp_cnt));
    chk("rsp_valid_cleared", W'(rsp_valid), W'(0));
  endtask

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] d0, k0, d1, k1;
    logic         exp_id;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b11, 128'h0123456789abcdef0123456789abcdef, 128'h0,
                128'hdeadbeef, 128'h1111, 1'b0};
    vecs[1] = '{2'b11, 128'h1, 128'h2, 128'h33333333_44444444, 128'hffff_0000, 1'b1};
    vecs[2] = '{2'b11, 128'hcafe_f00d, 128'h77, 128'h5, 128'h6, 1'b0};
    vecs[3] = '{2'b11, 128'h9, 128'ha, 128'hffffffff_ffffffff_ffffffff_ffffffff,
                128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b1};
    vecs[4] = '{2'b10, 128'h0, 128'h0, 128'h1234_5678, 128'h9abc_def0, 1'b1};
    vecs[5] = '{2'b01, 128'h55aa_55aa, 128'haa55_aa55, 128'h0, 128'h0, 1'b0};
    vecs[6] = '{2'b11, 128'h10, 128'h20, 128'h30, 128'h40, 1'b1};
    vecs[7] = '{2'b01, 128'h0f0f, 128'hf0f0, 128'h0, 128'h0, 1'b0};

    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_data0 = '0; req_key0 = '0; req_data1 = '0; req_key1 = '0;
    rsp_ready = 1'b0;
    spur      = 1'b0;
    hang      = 1'b0;
    #2;
    chk("rst_req_ready", W'(req_ready), W'(0));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_id", W'(rsp_id), W'(0));
    chk("rst_rsp_data", rsp_data, W'(0));
    chk("rst_rsp_err", W'(rsp_err), W'(0));
    chk("rst_core_start", W'(core_start), W'(0));
    chk("rst_core_data_in", core_data_in, W'(0));
    chk("rst_core_key", core_key, W'(0));
    chk("rst_core_rst", W'(core_rst), W'(0));
    chk("rst_done_count", W'(done_count), W'(0));
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_job(vecs[i].valid, vecs[i].d0, vecs[i].k0, vecs[i].d1, vecs[i].k1, vecs[i].exp_id, 0);
    end

    // Back-pressure in RESP with a spurious core_ready.
    do_job(2'b01, 128'h7777, 128'h8888, 128'h0, 128'h0, 1'b0, 20);

    // Asynchronous reset while waiting on the core.
    @(posedge clock);
    #1;
    req_valid = 2'b10;
    req_data1 = 128'hbeef; req_key1 = 128'hfeed;
    @(posedge clock);
    #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clock);
    #3;
    req_valid = 2'b11;
    reset_n   = 1'b0;
    #1;
    chk("mid_rst_req_ready", W'(req_ready), W'(2'b01));
    chk("mid_rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("mid_rst_rsp_id", W'(rsp_id), W'(0));
    chk("mid_rst_rsp_data", rsp_data, W'(0));
    chk("mid_rst_core_start", W'(core_start), W'(0));
    chk("mid_rst_core_data_in", core_data_in, W'(0));
    chk("mid_rst_core_key", core_key, W'(0));
    chk("mid_rst_done_count", W'(done_count), W'(0));
    req_valid = 2'b00;
    #2;
    reset_n = 1'b1;
    exp_cnt = 16'd0;
    repeat (2 * Lat + 4) @(posedge clock);
    do_job(2'b11, 128'habc, 128'hdef, 128'h123, 128'h456, 1'b0, 0);

    // Counter wrap.
    @(negedge clock);
    force dut.done_count_q = 16'hffff;
    @(posedge clock);
    @(negedge clock);
    release dut.done_count_q;
    @(negedge clock);
    chk("done_count_forced", W'(done_count), W'(16'hffff));
    exp_cnt = 16'hffff;
    do_job(2'b10, 128'h0, 128'h0, 128'h4242, 128'h2424, 1'b1, 0);

`ifdef XTEA_ARB_TIMEOUT_EN
    begin
      int  pulses;
      bit  got;
      hang   = 1'b1;
      pulses = 0;
      got    = 0;
      @(posedge clock);
      #1;
      req_valid = 2'b01;
      req_data0 = 128'h99; req_key0 = 128'h66;
      @(posedge clock);
      #1;
      req_valid = 2'b00;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clock);
        if (core_rst) pulses++;
        if (rsp_valid) got = 1;
      end
      chk("to_rsp_valid", W'(got), W'(1));
      chk("to_core_rst_pulses", W'(pulses), W'(1));
      chk("to_rsp_err", W'(rsp_err), W'(1));
      chk("to_rsp_data", rsp_data, W'(0));
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      exp_cnt   = exp_cnt + 16'd1;
      chk("to_done_count", W'(done_count), W'(exp_cnt));
      hang = 1'b0;
    end
`endif

    chk("req_ready_onehot", W'(dual_hits), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xtea_enc_arbiter.md
# xtea_enc_arbiter

Two-port round-robin controller that shares one `xtea_enc` core between two requesters. It accepts a (plaintext, key) job from either port with a valid/ready handshake and latches it. It then pulses `start` into the core, waits for the core's one-cycle `ready` pulse, and buffers the ciphertext until the requester takes it. It sits between the `xtea_enc` instance and the host-side request logic.

## Interface
- `WORD_SIZE`, 128, block/key width; must match the core.
- `TIMEOUT`, 255, maximum cycles from `core_start` to `core_ready`; used only with `XTEA_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-port job valid; bit i = port i.
- `req_ready`  out  2  per-port accept; at most one bit high.
- `req_data0`, `req_data1`  in  WORD_SIZE  plaintext per port.
- `req_key0`, `req_key1`  in  WORD_SIZE  key per port.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  port that issued the job.
- `rsp_data`  out  WORD_SIZE  ciphertext.
- `rsp_err`  out  1  job aborted by timeout; `rsp_data` is 0. Always 0 without the macro.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_data_in`  out  WORD_SIZE  latched plaintext; held stable from accept until return to IDLE.
- `core_key`  out  WORD_SIZE  latched key; same stability rule.
- `core_ready`  in  1  core completion pulse, one cycle.
- `core_data_out`  in  WORD_SIZE  core result; valid while `core_ready` = 1.
- `core_rst`  out  1  active-high reset request to the core; tied 0 without the macro.
- `done_count`  out  16  completed-job counter; wraps 0xFFFF → 0.

## Operation
- FSM states and transitions:
  - IDLE → LAUNCH on an accepted request.
  - LAUNCH → WAIT unconditionally.
  - WAIT → RESP on `core_ready`, or on timeout.
  - RESP → IDLE on `rsp_ready`.
- Arbitration in IDLE:
  - `req_ready[i]` = (state==IDLE) && grant==i.
  - grant = the port with `req_valid` set. If both are set, grant the port ≠ `last_grant`.
  - Accept = `req_valid[i]` && `req_ready[i]`. On accept, latch data, key and `rsp_id` = i.
- `req_ready` is combinational from `req_valid` and state; it depends on no other input.
- LAUNCH: `core_start` = 1 for exactly this cycle.
- WAIT: `core_start` = 0, so the core does not restart when it returns to its waiting state.
- WAIT exit: on `core_ready` = 1, capture `core_data_out` into the result register, set `rsp_err` = 0 and go to RESP.
- `core_ready` outside WAIT is ignored.
- RESP:
  - `rsp_valid` = 1; `rsp_id`, `rsp_data` and `rsp_err` stay stable until `rsp_ready`.
  - On `rsp_ready`: `last_grant` ← `rsp_id`; `done_count` +1 (including error jobs); go to IDLE.
- `req_ready` = 0 in every state except IDLE. No queueing beyond one job in flight.
- Reset values: state IDLE, `last_grant` = 1 (port 0 wins the first tie), `req_ready` per rule, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `rsp_err` 0, `core_start` 0, `core_data_in` 0, `core_key` 0, `core_rst` 0, `done_count` 0.
- Reset mid-job: all state clears immediately and asynchronously, and the job is lost. The core is reset by the top level, not by this block.

## Timing
- Accept edge at cycle t. `core_start` is high during cycle t+1. The core leaves its waiting state at edge t+2.
- `core_ready` at cycle r → `rsp_valid` = 1 from cycle r+1.
- Nominal core latency: 32 rounds × 3 cycles + ready stage, so `rsp_valid` rises about 99 cycles after accept.
- `rsp_ready` high in the same cycle `rsp_valid` rises → IDLE next cycle. A new accept is possible in the following cycle.
- Back-to-back throughput: one job per core latency + 3 cycles.
- A `req_valid` change while the block is not in IDLE has no effect. The requester must hold `req_valid` and its data until accepted.

## Configuration
- `XTEA_ARB_TIMEOUT_EN` defined:
  - An 8+ bit counter clears in LAUNCH and increments in WAIT.
  - When it reaches `TIMEOUT` without `core_ready`: `core_rst` = 1 for one cycle, `rsp_data` = 0, `rsp_err` = 1, go to RESP.
- Not defined: no counter. WAIT holds indefinitely for `core_ready`; `core_rst` and `rsp_err` are constant 0.

## Test plan
- Single job on port 0: pt 0x0123…CDEF, key 0x0 → `core_start` pulse at t+1; `rsp_valid` the cycle after `core_ready`; `rsp_id` = 0; `rsp_data` = core output; `done_count` = 1.
- Both ports valid continuously for 4 jobs → grant order 0,1,0,1; `req_ready` never has two bits set.
- `rsp_ready` held low 20 cycles in RESP → `rsp_data` stable; `req_ready` = 00 throughout; spurious `core_ready` ignored.
- Assert `reset_n` = 0 mid-WAIT, between edges → all outputs reach reset values without a clock edge; next job completes normally.
- With `XTEA_ARB_TIMEOUT_EN`, `TIMEOUT` = 10 and a core model that never readies → `core_rst` pulses once; `rsp_err` = 1 with `rsp_data` = 0; `done_count` increments.
- Force `done_count` = 0xFFFF, complete one job → 0x0000.
